// File: rtl/rr_slave_arbiter_if.sv
// rtl/rr_slave_arbiter_if.sv - request/ack/grant bundle between the crossbar side and a per-slave arbiter
interface rr_slave_arbiter_if;
  logic       req0;
  logic       req1;
  logic       slv_ack;
  logic [1:0] grant;
  logic       busy;
  logic       prio;
  logic       spurious_ack;
  logic       timeout;

  modport slave (
    input  req0, req1, slv_ack,
    output grant, busy, prio, spurious_ack, timeout
  );

  modport master (
    output req0, req1, slv_ack,
    input  grant, busy, prio, spurious_ack, timeout
  );
endinterface

// File: rtl/rr_slave_arbiter.sv
// rtl/rr_slave_arbiter.sv - two-master round-robin grant holder for one slave port; ARB_TIMEOUT_EN adds a BUSY watchdog
module rr_slave_arbiter #(
  parameter logic INIT_PRIO      = 1'b0,
  parameter int   TIMEOUT_CYCLES = 16,
  parameter int   CNT_W          = 5
) (
  input  logic clk,
  input  logic reset,
  rr_slave_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_chk
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  logic [0:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       prio_q, prio_d;
  logic       spur_q, spur_d;
  logic       win0, win1;

  // Single requester wins outright; a tie goes to the master named by prio.
  assign win0 = bus.req0 & (~bus.req1 | ~prio_q);
  assign win1 = bus.req1 & ~win0;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    spur_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wdog_d  = wdog_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        spur_d  = bus.slv_ack;
        grant_d = {win1, win0};
`ifdef ARB_TIMEOUT_EN
        wdog_d  = '0;
`endif
        if (win0 | win1) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Release hands priority to the non-owner, which is master1 exactly when master0 owned.
        if (bus.slv_ack) begin
          state_d = IDLE;
          grant_d = 2'b00;
          prio_d  = grant_q[0];
`ifdef ARB_TIMEOUT_EN
          wdog_d  = '0;
        end else if (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          grant_d = 2'b00;
          prio_d  = grant_q[0];
          wdog_d  = '0;
          tmo_d   = 1'b1;
        end else begin
          wdog_d  = wdog_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      prio_q  <= INIT_PRIO;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      spur_q  <= spur_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end
  assign bus.timeout = tmo_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant        = grant_q;
  assign bus.busy         = (state_q == BUSY);
  assign bus.prio         = prio_q;
  assign bus.spurious_ack = spur_q;

endmodule

// File: doc/rr_slave_arbiter.md
Name: rr_slave_arbiter

Overview:
- Per-slave two-master round-robin arbiter for the 2x2 crossbar; one instance per slave port.
- Inputs are the masters' requests already qualified by address decode (`reqN & addr[MSB]` match) and the slave's ack.
- Output is a registered one-hot grant that steers the crossbar request mux.
- The grant is held from award until the slave acks, so exactly one transaction is in flight per slave.

Parameters:
- INIT_PRIO, 1'b0, master holding highest priority after reset (0 = master0, 1 = master1).
- TIMEOUT_CYCLES, 16, cycles in BUSY without ack before forced release (used only with ARB_TIMEOUT_EN).
- CNT_W, 5, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  decoded request from master0 targeting this slave.
- req1  input  1  decoded request from master1 targeting this slave.
- slv_ack  input  1  slave acknowledge; one-cycle pulse completing the current transaction.
- grant  output  2  registered one-hot grant: 2'b01 = master0, 2'b10 = master1, 2'b00 = none; never 2'b11.
- busy  output  1  high while a transaction is owned (state BUSY).
- prio  output  1  current round-robin priority pointer (0 = master0 preferred).
- spurious_ack  output  1  one-cycle pulse when slv_ack arrives in IDLE.
- timeout  output  1  one-cycle pulse on watchdog release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, grant = 2'b00, busy = 0, prio = INIT_PRIO.
  - spurious_ack = 0, timeout = 0, watchdog = 0.
  - Reset mid-transaction drops the grant immediately; no completion is reported.
- States: IDLE, BUSY. All outputs are registered.
- IDLE:
  - No request: stay in IDLE, grant = 00.
  - Exactly one of req0/req1 high: that master wins regardless of prio.
  - Both high: the master selected by prio wins.
  - On a win: next edge grant = winner, busy = 1, state -> BUSY.
  - Latency: request sampled at edge k -> grant visible after edge k (one clock).
  - slv_ack high in IDLE: ignored for arbitration; spurious_ack = 1 for the following cycle.
- BUSY:
  - grant is held constant even if the owner deasserts its request (transaction already issued); a non-owner request only waits.
  - On slv_ack = 1 at edge k:
    - grant = 00, busy = 0, state -> IDLE.
    - prio = the non-owner (the last winner gets lowest priority).
    - This happens even if the same-cycle requests would re-award the same master.
- Turnaround:
  - At least one grant = 00 cycle between consecutive grants.
  - Back-to-back contention therefore alternates grants with a one-cycle gap: 01, 00, 10, 00, 01, ...
- Simultaneous events:
  - slv_ack together with a new request in BUSY: the completion is processed; the new request is arbitrated in the next IDLE cycle.
  - slv_ack and the watchdog expiring on the same edge: ack wins; timeout is not pulsed.
- prio changes only on completion or timeout, never on award.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Watchdog counts edges in BUSY; it clears on entry to BUSY and on slv_ack.
  - When the count reaches TIMEOUT_CYCLES without slv_ack: grant = 00, busy = 0, state -> IDLE, prio = non-owner, timeout = 1 for one cycle.
  - A slv_ack arriving after a timeout release is treated as spurious (spurious_ack pulses).
- Not defined:
  - No counter logic; BUSY waits for slv_ack indefinitely; timeout is tied 0.

Test Plan:
- Reset release, INIT_PRIO = 0; req0 = 1 at edge 1, slv_ack pulse at edge 4 -> grant = 01 after edge 1, busy = 1 over edges 1-3; grant = 00 and prio = 1 after edge 4.
- req0 = req1 = 1 held continuously, slv_ack pulsed 2 cycles after each grant -> grant sequence 01, 00, 10, 00, 01; never 11; prio toggles on each ack.
- Granted master0 drops req0 the cycle after grant while req1 = 1 -> grant stays 01 until slv_ack; grant = 10 appears one idle cycle after the ack.
- slv_ack pulsed in IDLE with no requests -> spurious_ack = 1 for exactly one cycle; grant and prio unchanged.
- reset asserted mid-BUSY with grant = 10 -> grant = 00, busy = 0, prio = INIT_PRIO immediately (before the next clock edge).
- ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16; req1 granted, no ack -> after 16 BUSY edges grant = 00, timeout pulses once, prio = 0; a late slv_ack then yields spurious_ack.
